// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and request-unit state encoding.
// Imported by the request unit and its sub-blocks.
package cpu_types_pkg;

  localparam int WORD_W  = 32;
  localparam int STALL_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2
  } reqstate_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous enable and async clear.
// Ports: clk, rst_n (async low clear), en (count strobe), cnt (value).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en && cnt != MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/request_unit.sv
// Memory request sequencer: fetch, optional data access, halt.
// Ports: CLK/nRST, ihit/dhit, decode in, enables, pcEN, counters.
module request_unit
  import cpu_types_pkg::*;
(
  input  logic               CLK,
  input  logic               nRST,
  input  logic               ihit,
  input  logic               dhit,
  input  logic               MemWr,
  input  logic               MemtoReg,
  input  logic               Halt,
  output logic               iREN,
  output logic               dREN,
  output logic               dWEN,
  output logic               pcEN,
  output logic               halt,
  output word_t              instr_cnt,
  output logic [STALL_W-1:0] stall_cnt
);

  reqstate_t state;
  logic      dren_q;
  logic      dwen_q;
  logic      halt_q;
  word_t     icnt;
  logic      fetch_ret;
  logic      data_ret;
  logic      stall_en;
  logic      mem_op;

  assign mem_op = MemWr | MemtoReg;

  always_comb begin
    fetch_ret = (state == FETCH) & ihit & ~Halt & ~mem_op;
    data_ret  = (state == DATA) & dhit;
    stall_en  = (state == DATA) & ~dhit;
    // Gated by nRST so a hit seen while held in reset never retires.
    pcEN      = nRST & (fetch_ret | data_ret);
    iREN      = (state == FETCH);
  end

  assign dREN      = dren_q;
  assign dWEN      = dwen_q;
  assign halt      = halt_q;
  assign instr_cnt = icnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= FETCH;
      dren_q <= 1'b0;
      dwen_q <= 1'b0;
      halt_q <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          if (ihit) begin
            if (Halt) begin
              state  <= HALTED;
              halt_q <= 1'b1;
            end else if (mem_op) begin
              state  <= DATA;
              // Store wins when both are decoded.
              dwen_q <= MemWr;
              dren_q <= MemtoReg & ~MemWr;
            end
          end
        end
        DATA: begin
          if (dhit) begin
            state  <= FETCH;
            dren_q <= 1'b0;
            dwen_q <= 1'b0;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state  <= FETCH;
          dren_q <= 1'b0;
          dwen_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      icnt <= '0;
    end else if (pcEN) begin
      icnt <= icnt + 1'b1;
    end
  end

  sat_counter #(
    .W (STALL_W)
  ) u_stall (
    .clk   (CLK),
    .rst_n (nRST),
    .en    (stall_en),
    .cnt   (stall_cnt)
  );

endmodule

// File: tb/tb_request_unit.sv
// Scoreboard bench for request_unit with a behavioural model.
// Driver pushes expected outputs; negedge monitor pops and compares.
module tb_request_unit;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit = 1'b0;
  logic        dhit = 1'b0;
  logic        MemWr = 1'b0;
  logic        MemtoReg = 1'b0;
  logic        Halt = 1'b0;
  logic        iREN, dREN, dWEN, pcEN, halt;
  logic [31:0] instr_cnt;
  logic [15:0] stall_cnt;

  request_unit dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .ihit      (ihit),
    .dhit      (dhit),
    .MemWr     (MemWr),
    .MemtoReg  (MemtoReg),
    .Halt      (Halt),
    .iREN      (iREN),
    .dREN      (dREN),
    .dWEN      (dWEN),
    .pcEN      (pcEN),
    .halt      (halt),
    .instr_cnt (instr_cnt),
    .stall_cnt (stall_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        iren;
    logic        dren;
    logic        dwen;
    logic        pcen;
    logic        hlt;
    logic [31:0] icnt;
    logic [15:0] scnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model: 0 = fetching, 1 = waiting on load,
  // 2 = waiting on store, 3 = halted.
  int          mode = 0;
  longint      m_icnt = 0;
  longint      m_scnt = 0;

  task automatic chk(input string nm, input longint act,
                     input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, req, $time);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("iREN", iREN, e.iren);
      chk("dREN", dREN, e.dren);
      chk("dWEN", dWEN, e.dwen);
      chk("pcEN", pcEN, e.pcen);
      chk("halt", halt, e.hlt);
      chk("instr_cnt", instr_cnt, e.icnt);
      chk("stall_cnt", stall_cnt, e.scnt);
    end
  end

  // One cycle: apply inputs just after the edge, predict outputs,
  // then advance the model across the next rising edge.
  task automatic step(input logic ih, input logic dh, input logic wr,
                      input logic rd, input logic hl, input logic rst);
    exp_t e;
    logic retire;
    ihit = ih; dhit = dh; MemWr = wr; MemtoReg = rd; Halt = hl;
    nRST = ~rst;
    if (rst) begin
      mode = 0; m_icnt = 0; m_scnt = 0;
    end
    retire = 1'b0;
    if (!rst) begin
      if (mode == 0 && ih && !hl && !wr && !rd) retire = 1'b1;
      if ((mode == 1 || mode == 2) && dh) retire = 1'b1;
    end
    e.iren = (mode == 0);
    e.dren = (mode == 1);
    e.dwen = (mode == 2);
    e.hlt  = (mode == 3);
    e.pcen = retire;
    e.icnt = m_icnt[31:0];
    e.scnt = m_scnt[15:0];
    exp_q.push_back(e);
    @(posedge CLK);
    if (!rst) begin
      if (retire) m_icnt = (m_icnt + 1) % 64'h1_0000_0000;
      case (mode)
        0: if (ih) begin
          if (hl) mode = 3;
          else if (wr) mode = 2;
          else if (rd) mode = 1;
        end
        1, 2: begin
          if (dh) mode = 0;
          else if (m_scnt < 65535) m_scnt++;
        end
        default: ;
      endcase
    end
    #1;
  endtask

  initial begin
    @(posedge CLK);
    #1;
    step(1, 1, 0, 0, 0, 1);
    // ALU ops right out of reset.
    repeat (3) step(1, 0, 0, 0, 0, 0);
    // Load with four wait cycles.
    step(1, 0, 0, 1, 0, 0);
    repeat (4) step(0, 0, 1, 1, 1, 0);
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // Store and load together: store wins.
    step(1, 0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    // Reset in the middle of a data wait.
    step(1, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    // Halt beats a store; later hits are ignored.
    step(1, 0, 1, 0, 1, 0);
    repeat (4) step(1, 1, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    // Randomized traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 1), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 40) == 0), ($urandom_range(0, 80) == 0));
    end
    // Stall counter saturation.
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 1, 0, 0);
    repeat (65540) step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    // Instruction counter wrap from all ones.
    step(0, 0, 0, 0, 0, 0);
    force dut.icnt = 32'hFFFF_FFFF;
    #0;
    release dut.icnt;
    m_icnt = 64'hFFFF_FFFF;
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d left expected 0",
               exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
